// File: rtl/stim_pkg.sv
// Shared types and defaults for the stimulus event player.
// Holds the playback state enum and the event-table entry layout.
package stim_pkg;

  localparam int DEF_NUM_INPUTS = 4;
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_DLY_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_DLY_W-1:0]                 delay;
    logic [DEF_NUM_INPUTS-1:0]            mask;
    logic [DEF_NUM_INPUTS*DEF_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/stim_event_mem.sv
// Event table: register array with one write port and two
// asynchronous read ports (payload of current event, delay of next).
module stim_event_mem #(
  parameter int DEPTH = 16,
  parameter int DLY_W = 16,
  parameter int PAY_W = 260,
  parameter int IW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [DLY_W-1:0] wdelay,
  input  logic [PAY_W-1:0] wpay,
  input  logic [IW-1:0]    paddr,
  output logic [PAY_W-1:0] rpay,
  input  logic [IW-1:0]    daddr,
  output logic [DLY_W-1:0] rdelay
);

  logic [DLY_W-1:0] delay_q [DEPTH];
  logic [PAY_W-1:0] pay_q   [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      delay_q[waddr] <= wdelay;
      pay_q[waddr]   <= wpay;
    end
  end

  assign rpay   = pay_q[paddr];
  assign rdelay = delay_q[daddr];

endmodule

// File: rtl/stim_event_player.sv
// Plays a loaded table of timed events onto monitor input channels,
// with per-channel strobes, optional looping and a global enable.
module stim_event_player
  import stim_pkg::*;
#(
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DLY_W      = DEF_DLY_W,
  localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clear,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [DLY_W-1:0]             ld_delay,
  input  logic [NUM_INPUTS-1:0]        ld_mask,
  input  logic [NUM_INPUTS*DATA_W-1:0] ld_data,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         loop,
  output logic [NUM_INPUTS*DATA_W-1:0] input_data,
  output logic [NUM_INPUTS-1:0]        new_input,
  output logic                         busy,
  output logic                         done,
  output logic [IW-1:0]                ev_idx
);

  localparam int CW    = $clog2(DEPTH + 1);
  localparam int DW    = NUM_INPUTS * DATA_W;
  localparam int PAY_W = NUM_INPUTS + DW;

  state_t           state;
  logic [CW-1:0]    count;
  logic [IW-1:0]    idx;
  logic [DLY_W-1:0] cnt;
  logic             loop_q;

  logic             we;
  logic             fire;
  logic             last;
  logic [IW-1:0]    nxt_addr;
  logic [DLY_W-1:0] nxt_delay;
  logic [PAY_W-1:0] cur_pay;
  logic [NUM_INPUTS-1:0] cur_mask;
  logic [DW-1:0]    cur_data;

  assign last = (CW'(idx) + CW'(1)) == count;

  // Delay port looks at entry 0 when (re)starting, else the next entry.
  assign nxt_addr = (state != WAIT || last) ? '0 : idx + IW'(1);

  assign ld_ready = (state != WAIT) && (count < CW'(DEPTH)) && !clear;
  assign we       = en && !rst && ld_valid && ld_ready;

  assign fire = en && !rst && !stop && (state == WAIT) && (cnt == '0);

  stim_event_mem #(
    .DEPTH (DEPTH),
    .DLY_W (DLY_W),
    .PAY_W (PAY_W),
    .IW    (IW)
  ) u_mem (
    .clk    (clk),
    .we     (we),
    .waddr  (count[IW-1:0]),
    .wdelay (ld_delay),
    .wpay   ({ld_mask, ld_data}),
    .paddr  (idx),
    .rpay   (cur_pay),
    .daddr  (nxt_addr),
    .rdelay (nxt_delay)
  );

  assign cur_mask = cur_pay[DW +: NUM_INPUTS];
  assign cur_data = cur_pay[0 +: DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      idx    <= '0;
      cnt    <= '0;
      loop_q <= 1'b0;
    end else if (en) begin
      if (we) count <= count + CW'(1);
      unique case (state)
        IDLE, DONE: begin
          if (clear) begin
            count <= '0;
            state <= IDLE;
          end else if (start && !stop) begin
            idx <= '0;
            if (count != '0) begin
              state  <= WAIT;
              cnt    <= nxt_delay;
              loop_q <= loop;
            end else begin
              state <= DONE;
            end
          end
        end
        WAIT: begin
          if (stop) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - DLY_W'(1);
          end else if (last && !loop_q) begin
            state <= DONE;
          end else begin
            idx <= nxt_addr;
            cnt <= nxt_delay;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    new_input  = fire ? cur_mask : '0;
    input_data = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (fire && cur_mask[i])
        input_data[i*DATA_W +: DATA_W] = cur_data[i*DATA_W +: DATA_W];
    end
  end

  assign busy   = (state == WAIT);
  assign done   = (state == DONE);
  assign ev_idx = idx;

endmodule
